// File: rtl/waveform_ram_arbiter.sv
// Round-robin arbiter sharing one RAM DMA read port among NUM_REQ waveform requesters.
// Optional watchdog on the RAM response: define WAVEFORM_RAM_ARBITER_TIMEOUT_EN.
module waveform_ram_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned NUM_REQ_WID  = 2,
  parameter int unsigned RAM_WID      = 32,
  parameter int unsigned RAM_WORD_WID = 16,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned TIMEOUT_WID  = 8
) (
  input  logic                       clk,
  input  logic                       rst_L,
  input  logic [NUM_REQ*RAM_WID-1:0] req_addr,
  input  logic [NUM_REQ-1:0]         req_read,
  output logic [NUM_REQ-1:0]         req_valid,
  output logic [RAM_WORD_WID-1:0]    req_word,
  output logic [NUM_REQ-1:0]         grant,
  output logic [RAM_WID-1:0]         ram_dma_addr,
  output logic                       ram_read,
  input  logic [RAM_WORD_WID-1:0]    ram_word,
  input  logic                       ram_valid,
  output logic                       timeout_err
);

  // Elaboration-time parameter sanity check.
  if ((2 ** NUM_REQ_WID) < NUM_REQ || TIMEOUT >= (2 ** TIMEOUT_WID)) begin : g_cfg_err
    $error("waveform_ram_arbiter: inconsistent parameter widths");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [NUM_REQ_WID-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ_WID-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]       req_valid_q, req_valid_d;
  logic [RAM_WORD_WID-1:0]  req_word_q, req_word_d;
  logic                     ram_read_q, ram_read_d;
  logic [RAM_WID-1:0]       ram_dma_addr_q, ram_dma_addr_d;

`ifdef WAVEFORM_RAM_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_WID-1:0]   wd_cnt_q, wd_cnt_d;
  logic                     timeout_err_q, timeout_err_d;
`endif

  logic [RAM_WID-1:0]       addr_arr [NUM_REQ];
  logic                     pick_vld;
  logic [NUM_REQ_WID-1:0]   pick_idx;
  logic [NUM_REQ_WID-1:0]   cand_idx;
  int                       cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*RAM_WID +: RAM_WID];
  end

  // First requesting index at or above rr_ptr, wrapping; scanned high-to-low so the nearest wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= int'(NUM_REQ)) begin
        cand = cand - int'(NUM_REQ);
      end
      cand_idx = NUM_REQ_WID'(cand);
      if (req_read[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_idx_d      = gnt_idx_q;
    grant_d        = grant_q;
    req_valid_d    = req_valid_q;
    req_word_d     = req_word_q;
    ram_read_d     = ram_read_q;
    ram_dma_addr_d = ram_dma_addr_q;
`ifdef WAVEFORM_RAM_ARBITER_TIMEOUT_EN
    wd_cnt_d       = wd_cnt_q;
    timeout_err_d  = timeout_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_idx_d          = pick_idx;
          grant_d            = '0;
          grant_d[pick_idx]  = 1'b1;
          ram_dma_addr_d     = addr_arr[pick_idx];
          ram_read_d         = 1'b1;
          state_d            = ST_ISSUE;
`ifdef WAVEFORM_RAM_ARBITER_TIMEOUT_EN
          wd_cnt_d           = '0;
`endif
        end
      end

      // Requester dropping req_read here does not abort; only the RAM ends the access.
      ST_ISSUE: begin
        if (ram_valid) begin
          ram_read_d  = 1'b0;
          req_word_d  = ram_word;
          req_valid_d = grant_q;
          state_d     = ST_RELEASE;
        end
`ifdef WAVEFORM_RAM_ARBITER_TIMEOUT_EN
        else if (wd_cnt_q == TIMEOUT_WID'(TIMEOUT - 1)) begin
          ram_read_d    = 1'b0;
          req_word_d    = '0;
          req_valid_d   = grant_q;
          timeout_err_d = 1'b1;
          state_d       = ST_RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + TIMEOUT_WID'(1);
        end
`endif
      end

      ST_RELEASE: begin
        if (!req_read[gnt_idx_q]) begin
          req_valid_d = '0;
          grant_d     = '0;
          rr_ptr_d    = (gnt_idx_q == NUM_REQ_WID'(NUM_REQ - 1)) ? '0
                                                                 : gnt_idx_q + NUM_REQ_WID'(1);
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      gnt_idx_q      <= '0;
      grant_q        <= '0;
      req_valid_q    <= '0;
      req_word_q     <= '0;
      ram_read_q     <= 1'b0;
      ram_dma_addr_q <= '0;
`ifdef WAVEFORM_RAM_ARBITER_TIMEOUT_EN
      wd_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_idx_q      <= gnt_idx_d;
      grant_q        <= grant_d;
      req_valid_q    <= req_valid_d;
      req_word_q     <= req_word_d;
      ram_read_q     <= ram_read_d;
      ram_dma_addr_q <= ram_dma_addr_d;
`ifdef WAVEFORM_RAM_ARBITER_TIMEOUT_EN
      wd_cnt_q       <= wd_cnt_d;
      timeout_err_q  <= timeout_err_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign req_valid    = req_valid_q;
  assign req_word     = req_word_q;
  assign ram_read     = ram_read_q;
  assign ram_dma_addr = ram_dma_addr_q;

`ifdef WAVEFORM_RAM_ARBITER_TIMEOUT_EN
  assign timeout_err  = timeout_err_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_waveform_ram_arbiter.sv
// Scoreboard bench for waveform_ram_arbiter: single access, contention, fairness,
// reset mid-access and watchdog behaviour (with or without WAVEFORM_RAM_ARBITER_TIMEOUT_EN).
module tb_waveform_ram_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 16;
  localparam int unsigned TO  = 8;
  localparam int unsigned TOW = 4;

  logic             clk;
  logic             rst_L;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_read;
  logic [NR-1:0]    req_valid;
  logic [DW-1:0]    req_word;
  logic [NR-1:0]    grant;
  logic [AW-1:0]    ram_dma_addr;
  logic             ram_read;
  logic [DW-1:0]    ram_word;
  logic             ram_valid;
  logic             timeout_err;

  typedef struct {
    int            idx;
    logic [DW-1:0] word;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  bit   ram_en;
  int   ram_lat;
  int   lat_cnt;

  waveform_ram_arbiter #(
    .NUM_REQ(NR), .NUM_REQ_WID(2), .RAM_WID(AW), .RAM_WORD_WID(DW),
    .TIMEOUT(TO), .TIMEOUT_WID(TOW)
  ) dut (
    .clk(clk), .rst_L(rst_L), .req_addr(req_addr), .req_read(req_read),
    .req_valid(req_valid), .req_word(req_word), .grant(grant),
    .ram_dma_addr(ram_dma_addr), .ram_read(ram_read), .ram_word(ram_word),
    .ram_valid(ram_valid), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_data(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hAEEF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset;
    rst_L     = 1'b0;
    req_read  = '0;
    ram_valid = 1'b0;
    tick();
    rst_L = 1'b1;
    tick();
  endtask

  // RAM model: answers ram_read after ram_lat cycles with a one-cycle ram_valid pulse.
  initial begin
    ram_valid = 1'b0;
    ram_word  = '0;
    lat_cnt   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!ram_en) begin
        lat_cnt = 0;
      end else if (ram_valid) begin
        ram_valid = 1'b0;
        lat_cnt   = 0;
      end else if (ram_read === 1'b1) begin
        lat_cnt++;
        if (lat_cnt >= ram_lat) begin
          ram_valid = 1'b1;
          ram_word  = ram_data(ram_dma_addr);
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic test_reset;
    rst_L = 1'b0;
    req_read = '0;
    tick();
    tick();
    checks++; if (grant !== 4'h0) begin failures++; $display("FAIL reset_grant actual=%h expected=%h", grant, 4'h0); end
    checks++; if (req_valid !== 4'h0) begin failures++; $display("FAIL reset_req_valid actual=%h expected=%h", req_valid, 4'h0); end
    checks++; if (req_word !== 16'h0) begin failures++; $display("FAIL reset_req_word actual=%h expected=%h", req_word, 16'h0); end
    checks++; if (ram_read !== 1'b0) begin failures++; $display("FAIL reset_ram_read actual=%b expected=0", ram_read); end
    checks++; if (ram_dma_addr !== 32'h0) begin failures++; $display("FAIL reset_ram_addr actual=%h expected=0", ram_dma_addr); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err actual=%b expected=0", timeout_err); end
    rst_L = 1'b1;
    tick();
  endtask

  task automatic test_single;
    exp_t e;
    int   n;
    set_addr(2, 32'h0000_1000);
    sb.push_back('{2, 16'hBEEF});
    req_read = 4'b0100;
    tick();
    checks++; if (ram_read !== 1'b1) begin failures++; $display("FAIL single_ram_read_latency actual=%b expected=1", ram_read); end
    checks++; if (ram_dma_addr !== 32'h1000) begin failures++; $display("FAIL single_addr actual=%h expected=%h", ram_dma_addr, 32'h1000); end
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant actual=%b expected=%b", grant, 4'b0100); end
    n = 0;
    while (req_valid === 4'h0 && n < 20) begin tick(); n++; end
    e = sb.pop_front();
    checks++; if (req_valid !== (4'b0001 << e.idx)) begin failures++; $display("FAIL single_req_valid actual=%b expected=%b", req_valid, 4'b0001 << e.idx); end
    checks++; if (req_word !== e.word) begin failures++; $display("FAIL single_req_word actual=%h expected=%h", req_word, e.word); end
    checks++; if (ram_read !== 1'b0) begin failures++; $display("FAIL single_ram_read_drop actual=%b expected=0", ram_read); end
    repeat (3) tick();
    checks++; if (req_valid !== 4'b0100 || req_word !== e.word) begin failures++; $display("FAIL single_hold actual=%b/%h expected=%b/%h", req_valid, req_word, 4'b0100, e.word); end
    req_read = 4'b0000;
    tick();
    checks++; if (req_valid !== 4'h0 || grant !== 4'h0) begin failures++; $display("FAIL single_release actual=%b/%b expected=0/0", req_valid, grant); end
  endtask

  task automatic test_contention;
    logic [AW-1:0] addrs [NR];
    exp_t          e;
    int            n;
    logic          prev_rd;
    int            order [5];
    do_reset();
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < int'(NR); i++) begin
      addrs[i] = 32'h0000_2000 + 32'(i) * 32'h111;
      set_addr(i, addrs[i]);
    end
    for (int t = 0; t < 5; t++) sb.push_back('{order[t], ram_data(addrs[order[t]])});
    req_read = 4'hF;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      prev_rd = ram_read;
      while (grant === 4'h0 && n < 20) begin prev_rd = ram_read; tick(); n++; end
      e = sb.pop_front();
      checks++; if (grant !== (4'b0001 << e.idx)) begin failures++; $display("FAIL contention_grant t=%0d actual=%b expected=%b", t, grant, 4'b0001 << e.idx); end
      checks++; if (prev_rd !== 1'b0 || ram_read !== 1'b1) begin failures++; $display("FAIL contention_gap t=%0d actual=%b%b expected=01", t, prev_rd, ram_read); end
      checks++; if (ram_dma_addr !== addrs[e.idx]) begin failures++; $display("FAIL contention_addr t=%0d actual=%h expected=%h", t, ram_dma_addr, addrs[e.idx]); end
      n = 0;
      while (req_valid === 4'h0 && n < 20) begin tick(); n++; end
      checks++; if (req_valid !== (4'b0001 << e.idx) || req_word !== e.word) begin failures++; $display("FAIL contention_data t=%0d actual=%b/%h expected=%b/%h", t, req_valid, req_word, 4'b0001 << e.idx, e.word); end
      if (t == 4) req_read = 4'h0;
      else req_read[e.idx] = 1'b0;
      tick();
      checks++; if (grant !== 4'h0 || ram_read !== 1'b0) begin failures++; $display("FAIL contention_idle t=%0d actual=%b/%b expected=0/0", t, grant, ram_read); end
      if (t < 4) req_read[e.idx] = 1'b1;
    end
  endtask

  task automatic test_fairness;
    exp_t e;
    int   n;
    do_reset();
    for (int i = 0; i < int'(NR); i++) set_addr(i, 32'h0000_5000 + 32'(i));
    sb.push_back('{0, ram_data(32'h5000)});
    sb.push_back('{1, ram_data(32'h5001)});
    sb.push_back('{3, ram_data(32'h5003)});
    req_read = 4'b1011;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (grant === 4'h0 && n < 20) begin tick(); n++; end
      e = sb.pop_front();
      checks++; if (grant !== (4'b0001 << e.idx)) begin failures++; $display("FAIL fairness_grant t=%0d actual=%b expected=%b", t, grant, 4'b0001 << e.idx); end
      n = 0;
      while (req_valid === 4'h0 && n < 20) begin tick(); n++; end
      checks++; if (req_word !== e.word) begin failures++; $display("FAIL fairness_word t=%0d actual=%h expected=%h", t, req_word, e.word); end
      if (e.idx == 3) begin
        req_read = 4'h0;
        tick();
      end else begin
        req_read[e.idx] = 1'b0;
        tick();
        req_read[e.idx] = 1'b1;
      end
    end
    req_read = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid_issue;
    exp_t e;
    int   n;
    bit   seen_valid;
    do_reset();
    ram_en = 1'b0;
    set_addr(1, 32'h0000_3000);
    req_read = 4'b0010;
    tick();
    checks++; if (ram_read !== 1'b1) begin failures++; $display("FAIL midrst_issue actual=%b expected=1", ram_read); end
    tick();
    rst_L = 1'b0;
    tick();
    rst_L = 1'b1;
    req_read = 4'h0;
    checks++; if (ram_read !== 1'b0 || grant !== 4'h0 || ram_dma_addr !== 32'h0) begin failures++; $display("FAIL midrst_clear actual=%b/%b/%h expected=0/0/0", ram_read, grant, ram_dma_addr); end
    ram_valid = 1'b1;
    ram_word  = 16'h1234;
    tick();
    ram_valid = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req_valid !== 4'h0) seen_valid = 1'b1;
      tick();
    end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL midrst_late_valid actual=%b expected=0", seen_valid); end
    checks++; if (req_word !== 16'h0 || grant !== 4'h0 || ram_read !== 1'b0) begin failures++; $display("FAIL midrst_outputs actual=%h/%b/%b expected=0/0/0", req_word, grant, ram_read); end
    ram_en = 1'b1;
    sb.push_back('{1, ram_data(32'h3000)});
    req_read = 4'b0010;
    tick();
    checks++; if (ram_read !== 1'b1 || grant !== 4'b0010) begin failures++; $display("FAIL midrst_idle_regrant actual=%b/%b expected=1/0010", ram_read, grant); end
    n = 0;
    while (req_valid === 4'h0 && n < 20) begin tick(); n++; end
    e = sb.pop_front();
    checks++; if (req_valid !== (4'b0001 << e.idx) || req_word !== e.word) begin failures++; $display("FAIL midrst_data actual=%b/%h expected=%b/%h", req_valid, req_word, 4'b0001 << e.idx, e.word); end
    req_read = 4'h0;
    tick();
  endtask

  task automatic test_timeout;
    int n;
    do_reset();
    ram_en = 1'b0;
    set_addr(2, 32'h0000_4000);
`ifdef WAVEFORM_RAM_ARBITER_TIMEOUT_EN
    begin
      exp_t e;
      sb.push_back('{2, 16'h0000});
      req_read = 4'b0100;
      tick();
      n = 0;
      while (ram_read === 1'b1 && n < 50) begin n++; tick(); end
      checks++; if (n != int'(TO)) begin failures++; $display("FAIL timeout_cycles actual=%0d expected=%0d", n, TO); end
      e = sb.pop_front();
      checks++; if (req_valid !== (4'b0001 << e.idx) || req_word !== e.word) begin failures++; $display("FAIL timeout_resp actual=%b/%h expected=%b/%h", req_valid, req_word, 4'b0001 << e.idx, e.word); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_set actual=%b expected=1", timeout_err); end
      req_read = 4'h0;
      tick();
      checks++; if (timeout_err !== 1'b1 || req_valid !== 4'h0) begin failures++; $display("FAIL timeout_sticky actual=%b/%b expected=1/0", timeout_err, req_valid); end
      do_reset();
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_err_reset actual=%b expected=0", timeout_err); end
    end
`else
    req_read = 4'b0100;
    tick();
    n = 0;
    while (ram_read === 1'b1 && n < 30) begin n++; tick(); end
    checks++; if (n != 30) begin failures++; $display("FAIL nowd_ram_read_held actual=%0d expected=30", n); end
    checks++; if (timeout_err !== 1'b0 || req_valid !== 4'h0) begin failures++; $display("FAIL nowd_no_err actual=%b/%b expected=0/0", timeout_err, req_valid); end
    do_reset();
`endif
    ram_en = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ram_en   = 1'b1;
    ram_lat  = 3;
    rst_L    = 1'b0;
    req_read = '0;
    req_addr = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_reset_mid_issue();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
